// File: rtl/serialize_vlen.sv
// Variable-length lane serializer.
// Takes one wide word of up to LANES lanes plus an active-lane count and
// emits the active lanes one per cycle, lane 0 first. The last lane carries
// an end-of-transaction flag. A new word loads on the same edge as the
// previous eot handshake, so consecutive words have no bubble between them.
//
// Handshake: a transfer happens on a rising edge where valid & ready are
// both high. A producer holds valid and data steady until that transfer.
// A consumer may raise or lower ready at any time. ready may depend on the
// other side's ready, but never on valid.
module serialize_vlen #(
    parameter int W     = 16,
    parameter int LANES = 4,
    parameter int CW    = $clog2(LANES + 1),
    parameter int DIN   = CW + LANES * W
) (
    input  logic           clk,
    input  logic           rst,
    output logic           din_ready,
    input  logic           din_valid,
    input  logic [DIN-1:0] din_data,
    input  logic           dout_ready,
    output logic           dout_valid,
    output logic [W:0]     dout_data
);

    localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [LANES*W-1:0]   hold_q, hold_d;

    logic                 busy;
    logic                 eot;
    logic                 accept;
    logic                 fire;
    logic [CW-1:0]        cnt_in;
    logic [CW-1:0]        n_eff;

    // Decode the incoming count, clamp it, and derive the handshake terms.
    always_comb begin
        busy       = (state_q == BUSY);
        cnt_in     = din_data[DIN-1 -: CW];
        n_eff      = (cnt_in > CW'(LANES)) ? CW'(LANES) : cnt_in;
        // cnt_q is never 0 while busy, so the subtraction cannot wrap in BUSY.
        eot        = busy && (CW'(idx_q) == (cnt_q - CW'(1)));
        // Accepting on the eot handshake is what removes the inter-word bubble.
        din_ready  = ~rst & (~busy | (dout_ready & eot));
        accept     = din_valid & din_ready;
        fire       = busy & dout_ready;
        dout_valid = busy;
        dout_data  = {eot, hold_q[idx_q*W +: W]};
    end

    // Next-state logic. A load from the input overrides the eot return to IDLE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        if (fire) begin
            if (eot) begin
                state_d = IDLE;
                idx_d   = '0;
            end else begin
                idx_d   = idx_q + IW'(1);
            end
        end
        if (accept) begin
            if (n_eff != '0) begin
                state_d = BUSY;
                idx_d   = '0;
                cnt_d   = n_eff;
                hold_d  = din_data[LANES*W-1:0];
            end else begin
                // An empty word is consumed and dropped; nothing is emitted.
                state_d = IDLE;
                idx_d   = '0;
            end
        end
    end

    // State register with synchronous reset; a reset discards any in-flight word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: tb/tb_serialize_vlen.sv
// Self-checking bench for serialize_vlen. Expected beats are queued when a
// word is accepted and popped when the DUT emits a lane.
module tb_serialize_vlen;
  localparam int W     = 16;
  localparam int LANES = 4;
  localparam int CW    = $clog2(LANES + 1);
  localparam int DIN   = CW + LANES * W;

  logic           clk;
  logic           rst;
  logic           din_ready;
  logic           din_valid;
  logic [DIN-1:0] din_data;
  logic           dout_ready;
  logic           dout_valid;
  logic [W:0]     dout_data;

  logic [W:0] exp_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         n_beats  = 0;
  bit         prev_stall = 0;
  logic [W:0] prev_data = '0;
  bit         rand_on = 0;

  serialize_vlen #(.W(W), .LANES(LANES)) dut (
    .clk        (clk),
    .rst        (rst),
    .din_ready  (din_ready),
    .din_valid  (din_valid),
    .din_data   (din_data),
    .dout_ready (dout_ready),
    .dout_valid (dout_valid),
    .dout_data  (dout_data)
  );

  // clock / reset
  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // driver: present a word and hold it until accepted
  task automatic send_word(input int c, input logic [LANES*W-1:0] l, input bit keep);
    int t;
    t = 0;
    din_data  = {CW'(c), l};
    din_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (din_ready) break;
      t++;
      if (t > 500) begin
        check("din_accept_timeout", 32'(t), 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!keep) din_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (exp_q.size() != 0 || dout_valid) begin
      @(negedge clk);
      t++;
      if (t > 2000) begin
        check("drain_timeout", 32'(t), 32'd0);
        break;
      end
    end
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // scoreboard: push on input accept, pop/compare on output handshake
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(dout_valid), 32'd1);
        check("stall_data", 32'(dout_data), 32'(prev_data));
      end
      if (dout_valid && dout_ready) begin
        n_beats++;
        if (exp_q.size() == 0) check("extra_beat", 32'(dout_data), 32'hFFFF_FFFF);
        else check("beat", 32'(dout_data), 32'(exp_q.pop_front()));
      end
      if (din_valid && din_ready) begin
        int c;
        int n;
        c = int'(din_data[DIN-1 -: CW]);
        n = (c > LANES) ? LANES : c;
        for (int i = 0; i < n; i++)
          exp_q.push_back({(i == n - 1), din_data[i*W +: W]});
      end
      prev_stall = dout_valid && !dout_ready;
      prev_data  = dout_data;
    end
  end

  initial begin
    int b0;
    int g;
    int t;
    rst        = 1;
    din_valid  = 0;
    din_data   = '0;
    dout_ready = 0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_din_ready", 32'(din_ready), 32'd0);
    check("rst_dout_valid", 32'(dout_valid), 32'd0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("post_rst_din_ready", 32'(din_ready), 32'd1);
    check("post_rst_dout_valid", 32'(dout_valid), 32'd0);

    // cnt=3 word, latency and din_ready during beats
    @(posedge clk); #1;
    dout_ready = 1;
    send_word(3, {16'h000D, 16'h000C, 16'h000B, 16'h000A}, 0);
    @(negedge clk);
    check("t1_latency_valid", 32'(dout_valid), 32'd1);
    check("t1_beat0", 32'(dout_data), 32'h0000A);
    check("t1_din_ready_b0", 32'(din_ready), 32'd0);
    @(negedge clk);
    check("t1_beat1", 32'(dout_data), 32'h0000B);
    check("t1_din_ready_b1", 32'(din_ready), 32'd0);
    @(negedge clk);
    check("t1_beat2", 32'(dout_data), 32'h1000C);
    check("t1_din_ready_eot", 32'(din_ready), 32'd1);
    wait_idle();

    // back-to-back cnt=4 then cnt=2
    @(posedge clk); #1;
    fork
      begin
        send_word(4, {16'h1004, 16'h1003, 16'h1002, 16'h1001}, 1);
        send_word(2, {16'h0, 16'h0, 16'h2002, 16'h2001}, 0);
      end
      begin
        t = 0;
        do begin
          @(negedge clk);
          t++;
        end while (!dout_valid && t < 50);
        check("b2b_start", 32'(dout_valid), 32'd1);
        for (int i = 0; i < 6; i++) begin
          check("b2b_valid", 32'(dout_valid && dout_ready), 32'd1);
          check("b2b_eot", 32'(dout_data[W]), 32'((i == 3) || (i == 5)));
          @(negedge clk);
        end
        check("b2b_idle_after", 32'(dout_valid), 32'd0);
      end
    join
    wait_idle();

    // cnt=0 dropped, then cnt=1
    @(posedge clk); #1;
    send_word(0, {16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD}, 0);
    @(negedge clk);
    check("cnt0_no_output", 32'(dout_valid), 32'd0);
    @(posedge clk); #1;
    send_word(1, {16'h0, 16'h0, 16'h0, 16'h1234}, 0);
    @(negedge clk);
    check("cnt1_beat", 32'(dout_data), 32'h11234);
    wait_idle();

    // cnt=7 clamps to 4
    @(posedge clk); #1;
    b0 = n_beats;
    send_word(7, {16'h7004, 16'h7003, 16'h7002, 16'h7001}, 0);
    wait_idle();
    check("clamp_beats", 32'(n_beats - b0), 32'd4);

    // random words with random output backpressure
    @(posedge clk); #1;
    rand_on = 1;
    fork
      begin
        while (rand_on) begin
          @(posedge clk); #1;
          dout_ready = 1'($urandom_range(0, 1));
        end
      end
      begin
        for (int k = 0; k < 200; k++) begin
          send_word(int'($urandom_range(0, 7)), {$urandom, $urandom}, 0);
          g = int'($urandom_range(0, 2));
          repeat (g) begin @(posedge clk); #1; end
        end
        rand_on = 0;
      end
    join
    dout_ready = 1;
    wait_idle();

    // reset on the second lane of a cnt=4 word
    @(posedge clk); #1;
    send_word(4, {16'h4444, 16'h3333, 16'h2222, 16'h1111}, 0);
    @(posedge clk); #1;
    rst = 1;
    dout_ready = 0;
    @(negedge clk);
    check("midrst_din_ready", 32'(din_ready), 32'd0);
    @(posedge clk); #1;
    rst = 0;
    dout_ready = 1;
    @(negedge clk);
    check("midrst_valid_after", 32'(dout_valid), 32'd0);
    b0 = n_beats;
    @(posedge clk); #1;
    send_word(2, {16'h0, 16'h0, 16'h5B5B, 16'h5A5A}, 0);
    wait_idle();
    check("midrst_fresh_beats", 32'(n_beats - b0), 32'd2);

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
